// File: rtl/shift_unit.sv
// ----------------------------------------------------------------------------
// shift_unit
//
// Two-stage pipelined 32-bit barrel shifter with valid/ready handshakes on
// both sides. Every operation is reduced to a single logical right shift:
//   S1 conditions the operand so that SLL and negative SRA can reuse the
//      right shifter (bit-reverse for SLL, invert for negative SRA), and
//      registers operand, shift amount, op and the invert flag.
//   S2 runs a 16/8/4/2/1 logarithmic right shifter with zero fill, undoes
//      the conditioning (reverse back for SLL, re-invert for negative SRA)
//      and registers the result onto out_data.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears all state
//   flush      synchronous kill of both stages; blocks same-cycle input
//   in_valid   request present on in_a / in_b / in_op
//   in_ready   request accepted this cycle (independent of in_valid)
//   in_a       operand to shift
//   in_b       shift amount 0..31
//   in_op      00 SRL, 01 SLL, 10 SRA, 11 pass
//   out_valid  result present on out_data
//   out_ready  consumer takes result this cycle
//   out_data   shift result, held stable while stalled
//   busy       either stage holds a valid operation
// ----------------------------------------------------------------------------
module shift_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [4:0]  in_b,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        OpSrl  = 2'b00,
        OpSll  = 2'b01,
        OpSra  = 2'b10,
        OpPass = 2'b11
    } op_e;

    function automatic logic [31:0] bit_rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    logic        s1_valid_q;
    logic [31:0] s1_opnd_q;
    logic [4:0]  s1_shamt_q;
    op_e         s1_op_q;
    logic        s1_inv_q;

    // ------------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------------
    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    // flush forces in_ready low so a same-cycle request is never taken.
    assign in_ready = s1_adv && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = s1_valid_q || out_valid;

    // ------------------------------------------------------------------------
    // S1 operand conditioning
    // ------------------------------------------------------------------------
    logic [31:0] cond_opnd;
    logic [4:0]  cond_shamt;
    logic        cond_inv;

    always_comb begin
        cond_opnd  = in_a;
        cond_shamt = in_b;
        cond_inv   = 1'b0;
        case (op_e'(in_op))
            // Left shift becomes a right shift of the mirrored word.
            OpSll: cond_opnd = bit_rev(in_a);
            // Negative SRA: ~(~a >> b) fills ones from the top.
            OpSra: begin
                if (in_a[31]) begin
                    cond_opnd = ~in_a;
                    cond_inv  = 1'b1;
                end
            end
            OpPass: cond_shamt = 5'd0;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // S2 logarithmic right shifter and fix-up
    // ------------------------------------------------------------------------
    logic [31:0] sh16;
    logic [31:0] sh8;
    logic [31:0] sh4;
    logic [31:0] sh2;
    logic [31:0] sh1;
    logic [31:0] fix;
    logic [31:0] s2_result;

    always_comb begin
        sh16      = s1_shamt_q[4] ? {16'd0, s1_opnd_q[31:16]} : s1_opnd_q;
        sh8       = s1_shamt_q[3] ? {8'd0, sh16[31:8]}        : sh16;
        sh4       = s1_shamt_q[2] ? {4'd0, sh8[31:4]}         : sh8;
        sh2       = s1_shamt_q[1] ? {2'd0, sh4[31:2]}         : sh4;
        sh1       = s1_shamt_q[0] ? {1'd0, sh2[31:1]}         : sh2;
        fix       = (s1_op_q == OpSll) ? bit_rev(sh1) : sh1;
        s2_result = s1_inv_q ? ~fix : fix;
    end

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_opnd_q  <= 32'd0;
            s1_shamt_q <= 5'd0;
            s1_op_q    <= OpSrl;
            s1_inv_q   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
        end else if (flush) begin
            // Data registers keep stale contents; only the valids matter.
            s1_valid_q <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (s2_adv) begin
                out_valid <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data <= s2_result;
                end
            end
            if (s1_adv) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_opnd_q  <= cond_opnd;
                    s1_shamt_q <= cond_shamt;
                    s1_op_q    <= op_e'(in_op);
                    s1_inv_q   <= cond_inv;
                end
            end
        end
    end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; port list as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset; clears all state.
REQ-004 flush  input  1  synchronous kill of all in-flight operations.
REQ-005 in_valid  input  1  request present on in_a/in_b/in_op.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 in_a  input  32  operand to shift.
REQ-008 in_b  input  5  shift amount, 0..31.
REQ-009 in_op  input  2  operation: 00 SRL, 01 SLL, 10 SRA, 11 pass.
REQ-010 out_valid  output  1  result present on out_data.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 out_data  output  32  shift result.
REQ-013 busy  output  1  high when any pipeline stage holds a valid operation.

Function
REQ-014 Transfer on input SHALL occur when in_valid && in_ready at a rising edge; on output when out_valid && out_ready.
REQ-015 Pipeline SHALL be two registered stages: S1 (operand conditioning), S2 (shift + result fix-up, drives out_*).
REQ-016 S1 conditioning SHALL be: SLL -> bit-reverse in_a; SRA with in_a[31]=1 -> bitwise invert in_a and set inv flag; SRL and pass -> in_a unchanged.
REQ-017 S1 SHALL register the conditioned operand, shamt (forced to 0 for op 11), op and inv flag.
REQ-018 S2 SHALL logically right-shift the S1 operand by shamt with zero fill (5-level 16/8/4/2/1 datapath), then bit-reverse for SLL, invert for inv=1, and register the result.
REQ-019 Results SHALL equal: SRL a>>b, SLL a<<b (modulo 2^32), SRA arithmetic a>>>b, pass a.
REQ-020 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no stall; throughput 1 op/cycle.
REQ-021 S2 SHALL advance when !out_valid || out_ready; S1 SHALL advance when S1 empty or S2 advances.
REQ-022 in_ready SHALL be combinationally !s1_valid || s2_advance; it SHALL NOT depend on in_valid.
REQ-023 While out_valid && !out_ready, out_data SHALL hold stable and no result SHALL be lost or duplicated.
REQ-024 Results SHALL leave in acceptance order.
REQ-025 b=0 SHALL return in_a unchanged for every op.
REQ-026 flush=1 SHALL clear both stage valids at the edge, drop any same-cycle input transfer, and force in_ready=0 that cycle; out_data value is don't-care after flush.
REQ-027 flush and rst both asserted: rst SHALL dominate.
REQ-028 busy SHALL equal s1_valid || out_valid.

Reset
REQ-029 On rst assertion, asynchronously: out_valid=0, out_data=0x0000_0000, s1_valid=0, all stage data and flags=0, busy=0.
REQ-030 in_ready SHALL be 1 during and immediately after reset (pipeline empty).
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; no result SHALL appear after release without a new input transfer.

Verification
REQ-032 SRL a=0x8000_0000 b=31, out_ready=1 -> out_valid 2 cycles later, out_data=0x0000_0001.
REQ-033 SLL a=0x0000_0001 b=4 -> 0x0000_0010; SLL a=0xFFFF_FFFF b=31 -> 0x8000_0000.
REQ-034 SRA a=0xF000_0000 b=4 -> 0xFF00_0000; SRA a=0x7000_0000 b=4 -> 0x0700_0000; op=11 a=0x1234_5678 b=7 -> 0x1234_5678.
REQ-035 Backpressure: 3 back-to-back SRL b=1 on a=2,4,6 with out_ready=0 for 4 cycles -> out_data held at 0x1, in_ready=0 once both stages are full, third request stalls; after release, outputs 1,2,3 in order, no loss.
REQ-036 Flush with both stages full -> next cycle out_valid=0, busy=0; new request afterwards completes in 2 cycles with correct value.
REQ-037 rst pulse with an operation in S1 -> out_valid=0, out_data=0 immediately; no stale result after release.
